// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the byte-command debug controller.
//   - command opcodes carried in the first byte of every command
//   - command FSM state encoding
//   - bit positions inside the STATUS response byte
package debug_pkg;

    localparam logic [7:0] OP_WR     = 8'h01;
    localparam logic [7:0] OP_RD     = 8'h02;
    localparam logic [7:0] OP_DIV    = 8'h03;
    localparam logic [7:0] OP_RUN    = 8'h04;
    localparam logic [7:0] OP_HALT   = 8'h05;
    localparam logic [7:0] OP_STEP   = 8'h06;
    localparam logic [7:0] OP_STATUS = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IDX  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int STAT_ERR  = 0;
    localparam int STAT_RUN  = 1;
    localparam int STAT_STEP = 2;

    function automatic logic [7:0] status_byte(input logic stepping,
                                               input logic running,
                                               input logic err);
        logic [7:0] v;
        v            = 8'h00;
        v[STAT_STEP] = stepping;
        v[STAT_RUN]  = running;
        v[STAT_ERR]  = err;
        return v;
    endfunction

endpackage

// File: rtl/debug_ctrl_clk_enable_gen.sv
// clk_enable_gen: core clock-enable generator with run, halt and N-step modes.
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   cmd_run      start free running (one-cycle strobe)
//   cmd_halt     stop, abort any step in progress (one-cycle strobe)
//   cmd_step     start stepping step_n pulses (one-cycle strobe)
//   cmd_div      divider was rewritten; restart the period (one-cycle strobe)
//   step_n       number of pulses for cmd_step
//   divider      period = divider+1 cycles
//   clk_en_o     one-cycle clock-enable pulse (registered)
//   running      free-running mode active
//   stepping     step mode active
module clk_enable_gen
    import debug_pkg::*;
#(
    parameter int COUNTER_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_run,
    input  logic                    cmd_halt,
    input  logic                    cmd_step,
    input  logic                    cmd_div,
    input  logic [COUNTER_BITS-1:0] step_n,
    input  logic [COUNTER_BITS-1:0] divider,
    output logic                    clk_en_o,
    output logic                    running,
    output logic                    stepping
);

    logic [COUNTER_BITS-1:0] r_tick;
    logic [COUNTER_BITS-1:0] r_remaining;
    logic                    r_running;
    logic                    r_stepping;
    logic                    r_clk_en;

    // Commands take priority over a tick match in the same cycle, so a
    // command cycle never emits a pulse.  STEP 0 is treated as no command.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick      <= '0;
            r_remaining <= '0;
            r_running   <= 1'b0;
            r_stepping  <= 1'b0;
            r_clk_en    <= 1'b0;
        end else if (cmd_halt) begin
            r_running  <= 1'b0;
            r_stepping <= 1'b0;
            r_tick     <= '0;
            r_clk_en   <= 1'b0;
        end else if (cmd_run) begin
            r_running  <= 1'b1;
            r_stepping <= 1'b0;
            r_tick     <= '0;
            r_clk_en   <= 1'b0;
        end else if (cmd_step && (step_n != '0)) begin
            r_running   <= 1'b0;
            r_stepping  <= 1'b1;
            r_remaining <= step_n;
            r_tick      <= '0;
            r_clk_en    <= 1'b0;
        end else if (cmd_div) begin
            r_tick   <= '0;
            r_clk_en <= 1'b0;
        end else if (r_running || r_stepping) begin
            if (r_tick == divider) begin
                r_clk_en <= 1'b1;
                r_tick   <= '0;
                if (r_stepping) begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == COUNTER_BITS'(1)) begin
                        r_stepping <= 1'b0;
                    end
                end
            end else begin
                r_tick   <= r_tick + 1'b1;
                r_clk_en <= 1'b0;
            end
        end else begin
            r_clk_en <= 1'b0;
        end
    end

    assign clk_en_o = r_clk_en;
    assign running  = r_running;
    assign stepping = r_stepping;

endmodule

// File: rtl/debug_ctrl.sv
// debug_ctrl: byte-command debug controller between a UART byte interface
// and a core under debug.  Writes NUM_OUT output registers, snapshots NUM_IN
// input channels and drives the core clock-enable generator.
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   rx_data/valid/ready   command byte stream in (valid/ready handshake)
//   tx_data/valid/ready   response byte stream out (valid/ready handshake)
//   clk_en_o              core clock-enable pulse
//   out_bus               output registers, reg k at [k*BUS_WIDTH +: BUS_WIDTH]
//   in_bus                input channels, same packing
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | wait for opcode; RUN/HALT/STATUS complete here
// S_IDX  | wait for index byte of WR/RD; RD snapshots input here
// S_DATA | collect W little-endian data bytes for WR/DIV/STEP
// S_RESP | send response bytes, rx blocked
module debug_ctrl
    import debug_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int NUM_OUT      = 4,
    parameter int NUM_IN       = 2,
    parameter int COUNTER_BITS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         clk_en_o,
    output logic [NUM_OUT*BUS_WIDTH-1:0] out_bus,
    input  logic [NUM_IN*BUS_WIDTH-1:0]  in_bus
);

    localparam int W   = BUS_WIDTH / 8;
    localparam int BCW = (W > 1) ? $clog2(W) : 1;

    state_t                  r_state;
    logic [7:0]              r_opcode;
    logic [7:0]              r_idx;
    logic [BCW-1:0]          r_byte_cnt;
    logic [BUS_WIDTH-1:0]    r_shift;
    logic [BUS_WIDTH-1:0]    r_resp_word;
    logic [BUS_WIDTH-1:0]    r_out [NUM_OUT];
    logic [COUNTER_BITS-1:0] r_divider;
    logic                    r_err;
    logic                    r_rx_ready;
    logic                    r_tx_valid;
    logic [7:0]              r_tx_data;

    logic                    w_rx_hs;
    logic                    w_last_byte;
    logic                    w_resp_last;
    logic                    w_idx_ok;
    logic                    w_in_range;
    logic [BUS_WIDTH-1:0]    w_word_next;
    logic [BUS_WIDTH-1:0]    w_in_sel;
    logic [COUNTER_BITS-1:0] w_word_cb;
    logic                    w_cmd_run;
    logic                    w_cmd_halt;
    logic                    w_cmd_step;
    logic                    w_cmd_div;
    logic                    w_running;
    logic                    w_stepping;

    assign w_rx_hs     = rx_valid && r_rx_ready;
    assign w_last_byte = (r_byte_cnt == BCW'(W - 1));
    assign w_resp_last = (r_opcode == OP_STATUS) || (r_byte_cnt == BCW'(W - 1));
    assign w_idx_ok    = ({1'b0, r_idx} < 9'(NUM_OUT));
    assign w_in_range  = ({1'b0, rx_data} < 9'(NUM_IN));

    // Bytes arrive LSB first: shifting each new byte in at the top leaves
    // the first byte in the low lane after W bytes.
    generate
        if (BUS_WIDTH == 8) begin : g_word8
            assign w_word_next = rx_data;
        end else begin : g_wordn
            assign w_word_next = {rx_data, r_shift[BUS_WIDTH-1:8]};
        end
    endgenerate

    // Divider / step count take the low COUNTER_BITS of the data word,
    // zero-extended when the counter is wider than the bus.
    always_comb begin
        w_word_cb = '0;
        for (int b = 0; (b < COUNTER_BITS) && (b < BUS_WIDTH); b++) begin
            w_word_cb[b] = w_word_next[b];
        end
    end

    // Out-of-range RD index leaves the snapshot at zero.
    always_comb begin
        w_in_sel = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rx_data == 8'(k)) begin
                w_in_sel = in_bus[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Generator commands fire on the accepting handshake so they take
    // effect on the same edge as the FSM transition.
    assign w_cmd_run  = (r_state == S_IDLE) && w_rx_hs && (rx_data == OP_RUN);
    assign w_cmd_halt = (r_state == S_IDLE) && w_rx_hs && (rx_data == OP_HALT);
    assign w_cmd_step = (r_state == S_DATA) && w_rx_hs && w_last_byte && (r_opcode == OP_STEP);
    assign w_cmd_div  = (r_state == S_DATA) && w_rx_hs && w_last_byte && (r_opcode == OP_DIV);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_opcode    <= 8'h00;
            r_idx       <= 8'h00;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_resp_word <= '0;
            r_divider   <= '0;
            r_err       <= 1'b0;
            r_rx_ready  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_out[k] <= '0;
            end
        end else begin
            if (r_state != S_RESP) begin
                r_rx_ready <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rx_hs) begin
                        r_opcode   <= rx_data;
                        r_byte_cnt <= '0;
                        case (rx_data)
                            OP_WR, OP_RD:    r_state <= S_IDX;
                            OP_DIV, OP_STEP: r_state <= S_DATA;
                            OP_RUN, OP_HALT: r_state <= S_IDLE;
                            OP_STATUS: begin
                                r_state    <= S_RESP;
                                r_rx_ready <= 1'b0;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= status_byte(w_stepping, w_running, r_err);
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_IDX: begin
                    if (w_rx_hs) begin
                        r_idx <= rx_data;
                        if (r_opcode == OP_RD) begin
                            r_state     <= S_RESP;
                            r_rx_ready  <= 1'b0;
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= w_in_sel[7:0];
                            r_resp_word <= w_in_sel >> 8;
                            if (!w_in_range) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_hs) begin
                        r_shift    <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_last_byte) begin
                            r_state <= S_IDLE;
                            if (r_opcode == OP_WR) begin
                                if (w_idx_ok) begin
                                    for (int k = 0; k < NUM_OUT; k++) begin
                                        if (r_idx == 8'(k)) begin
                                            r_out[k] <= w_word_next;
                                        end
                                    end
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end else if (r_opcode == OP_DIV) begin
                                r_divider <= w_word_cb;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && tx_ready) begin
                        if (w_resp_last) begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            if (r_opcode == OP_STATUS) begin
                                r_err <= 1'b0;
                            end
                        end else begin
                            r_tx_data   <= r_resp_word[7:0];
                            r_resp_word <= r_resp_word >> 8;
                            r_byte_cnt  <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
            assign out_bus[g*BUS_WIDTH +: BUS_WIDTH] = r_out[g];
        end
    endgenerate

    assign rx_ready = r_rx_ready;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;

    clk_enable_gen #(
        .COUNTER_BITS(COUNTER_BITS)
    ) u_clk_enable_gen (
        .clk      (clk),
        .reset    (reset),
        .cmd_run  (w_cmd_run),
        .cmd_halt (w_cmd_halt),
        .cmd_step (w_cmd_step),
        .cmd_div  (w_cmd_div),
        .step_n   (w_word_cb),
        .divider  (r_divider),
        .clk_en_o (clk_en_o),
        .running  (w_running),
        .stepping (w_stepping)
    );

endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: directed, self-checking bench for debug_ctrl with default
// parameters (32-bit words, 4 outputs, 2 inputs).
module tb_debug_ctrl;
    import debug_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         clk_en_o;
    logic [127:0] out_bus;
    logic [63:0]  in_bus;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_ctrl #(
        .BUS_WIDTH(32), .NUM_OUT(4), .NUM_IN(2), .COUNTER_BITS(32)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .clk_en_o(clk_en_o), .out_bus(out_bus), .in_bus(in_bus)
    );

    typedef struct {
        logic [7:0]   idx;
        logic [31:0]  data;
        logic [127:0] exp_out;
        logic [7:0]   exp_status;
    } wr_vec_t;

    wr_vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("rx_ready timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp, input int stall);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!tx_valid) begin
            check({name, " tx_valid timeout"}, 0, 1);
        end else begin
            for (int s = 0; s < stall; s++) begin
                check({name, " stalled data"}, tx_data, exp);
                check({name, " rx_ready in resp"}, rx_ready, 0);
                @(negedge clk);
            end
            check(name, tx_data, exp);
            check({name, " tx_valid"}, tx_valid, 1);
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
            tx_ready = 1'b0;
        end
    endtask

    task automatic status(input string name, input logic [7:0] exp);
        send_byte(OP_STATUS);
        recv_byte(name, exp, 0);
    endtask

    // Writes a register; out_bus must not move before the last data byte.
    task automatic wr(input logic [7:0] idx, input logic [31:0] d, input logic [127:0] prev);
        send_byte(OP_WR);
        send_byte(idx);
        for (int i = 0; i < 3; i++) send_byte(d[i*8 +: 8]);
        check("wr out_bus before last byte", out_bus, prev);
        send_byte(d[31:24]);
    endtask

    // Samples clk_en_o on the falling edge for a window of cycles.
    task automatic count_pulses(input int cycles, output int n, output int first,
                                output int last, output int bad_gap, input int gap);
        int prev;
        n = 0; first = -1; last = -1; bad_gap = 0; prev = -1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (clk_en_o) begin
                if (first < 0) first = c;
                if (prev >= 0 && (c - prev) != gap) bad_gap++;
                prev = c;
                last = c;
                n++;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, last, bad;
        logic [127:0] prev_out;

        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        in_bus = {32'h12345678, 32'hA1B2C3D4};

        vecs[0] = '{8'd2, 32'hDEADBEEF, 128'h00000000_DEADBEEF_00000000_00000000, 8'h00};
        vecs[1] = '{8'd0, 32'h11223344, 128'h00000000_DEADBEEF_00000000_11223344, 8'h00};
        vecs[2] = '{8'd3, 32'hA5A5A5A5, 128'hA5A5A5A5_DEADBEEF_00000000_11223344, 8'h00};
        vecs[3] = '{8'd7, 32'hFFFFFFFF, 128'hA5A5A5A5_DEADBEEF_00000000_11223344, 8'h01};
        vecs[4] = '{8'd1, 32'hCAFEF00D, 128'hA5A5A5A5_DEADBEEF_CAFEF00D_11223344, 8'h00};
        vecs[5] = '{8'd0, 32'h00000000, 128'hA5A5A5A5_DEADBEEF_CAFEF00D_00000000, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_bus", out_bus, 0);
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_data", tx_data, 0);
        check("reset rx_ready", rx_ready, 0);
        check("reset clk_en_o", clk_en_o, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rx_ready after release", rx_ready, 1);

        // Register writes, each followed by a STATUS read
        prev_out = '0;
        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].idx, vecs[v].data, prev_out);
            check($sformatf("wr vec%0d out_bus", v), out_bus, vecs[v].exp_out);
            status($sformatf("wr vec%0d status", v), vecs[v].exp_status);
            prev_out = vecs[v].exp_out;
        end

        // RD channel 0, no stall
        send_byte(OP_RD); send_byte(8'd0);
        recv_byte("rd0 b0", 8'hD4, 0);
        recv_byte("rd0 b1", 8'hC3, 0);
        recv_byte("rd0 b2", 8'hB2, 0);
        recv_byte("rd0 b3", 8'hA1, 0);

        // RD channel 1; input changes after the idx byte must not matter
        send_byte(OP_RD); send_byte(8'd1);
        in_bus = 64'hFFFFFFFF_00000000;
        recv_byte("rd1 b0", 8'h78, 3);
        recv_byte("rd1 b1", 8'h56, 3);
        recv_byte("rd1 b2", 8'h34, 3);
        recv_byte("rd1 b3", 8'h12, 3);
        status("rd1 status", 8'h00);

        // RD out of range -> zeros and err
        send_byte(OP_RD); send_byte(8'd5);
        for (int i = 0; i < 4; i++) recv_byte("rd oob byte", 8'h00, 0);
        status("rd oob status", 8'h01);
        status("rd oob status cleared", 8'h00);

        // DIV 3 + RUN: period 4
        send_byte(OP_DIV); send_word(32'd3);
        send_byte(OP_RUN);
        count_pulses(24, n, first, last, bad, 4);
        check("run div3 pulse count>=4", (n >= 4), 1);
        check("run div3 gaps", bad, 0);
        status("run status", 8'h02);
        send_byte(OP_HALT);
        count_pulses(12, n, first, last, bad, 4);
        check("halt no pulses", n, 0);
        status("halt status", 8'h00);

        // DIV 0 + STEP 5: five consecutive pulses
        send_byte(OP_DIV); send_word(32'd0);
        send_byte(OP_STEP); send_word(32'd5);
        count_pulses(15, n, first, last, bad, 1);
        check("step5 count", n, 5);
        check("step5 consecutive", last - first, 4);
        status("step5 status", 8'h00);

        // STEP 0: nothing happens
        send_byte(OP_STEP); send_word(32'd0);
        count_pulses(10, n, first, last, bad, 1);
        check("step0 count", n, 0);
        status("step0 status", 8'h00);

        // DIV 9 + STEP 3: stepping visible in status, then exactly 3 pulses
        send_byte(OP_DIV); send_word(32'd9);
        send_byte(OP_STEP); send_word(32'd3);
        status("step3 status busy", 8'h04);
        count_pulses(50, n, first, last, bad, 10);
        check("step3 count", n, 3);
        check("step3 gaps", bad, 0);
        status("step3 status done", 8'h00);

        // STEP while running cancels running
        send_byte(OP_DIV); send_word(32'd0);
        send_byte(OP_RUN);
        send_byte(OP_STEP); send_word(32'd2);
        repeat (10) @(negedge clk);
        status("step over run status", 8'h00);

        // Unknown opcode
        send_byte(8'h55);
        status("bad opcode status", 8'h01);
        status("bad opcode status cleared", 8'h00);

        // Reset in the middle of a long step
        send_byte(OP_DIV); send_word(32'd1);
        send_byte(OP_STEP); send_word(32'd100);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid-step reset clk_en_o", clk_en_o, 0);
        check("mid-step reset out_bus", out_bus, 0);
        check("mid-step reset rx_ready", rx_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        count_pulses(12, n, first, last, bad, 1);
        check("after reset no pulses", n, 0);

        // Reset in the middle of a RD response
        in_bus = {32'h0BADF00D, 32'h00000000};
        send_byte(OP_RD); send_byte(8'd1);
        @(negedge clk);
        check("mid-rd tx_valid before reset", tx_valid, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid-rd reset tx_valid", tx_valid, 0);
        check("mid-rd reset tx_data", tx_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid-rd rx_ready after release", rx_ready, 1);

        // Normal operation afterwards
        send_byte(OP_RD); send_byte(8'd1);
        recv_byte("post-reset rd b0", 8'h0D, 1);
        recv_byte("post-reset rd b1", 8'hF0, 0);
        recv_byte("post-reset rd b2", 8'hAD, 0);
        recv_byte("post-reset rd b3", 8'h0B, 0);
        wr(8'd3, 32'h0BADF00D, 128'h0);
        check("post-reset wr out_bus", out_bus, 128'h0BADF00D_00000000_00000000_00000000);
        status("post-reset status", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
